fetch_stage: RTL

- IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request/response handshake, and writes the IF/ID pipeline register.
- The decode stage consumes the IF/ID register and generates the control word, which is zeroed on ID flush.
- Takes the IF flush, jump/bne/jr redirect and load-use stall signals produced by the hazard/discard logic.
- Tolerates variable-latency instruction memory through a 3-state FSM and a one-entry hold buffer.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/next_pc_sel.sv | 32 +++
 rtl/fetch_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the IF stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect priority mux (jr > branch_taken > jump); zero latency, purely combinational.
// Selected target is word-aligned by forcing bits [1:0] to zero.
module next_pc_sel
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
  output logic            redirect,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    raw_target = jump_target;
    if (jr) begin
      raw_target = jr_target;
    end else if (branch_taken) begin
      raw_target = branch_target;
    end
  end

  assign redirect = jr | branch_taken | jump;
  assign target   = {raw_target[XLEN-1:2], 2'b00};

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem request/response handshake and IF/ID register; 1 instr/cycle on zero-wait memory.
// Backpressure: stall freezes PC and IF/ID; a late response under stall parks in a one-entry hold buffer.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            if_flush,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  logic            redirect;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] pc_plus4;
  logic            load_instr;
  logic [XLEN-1:0] load_dat;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .redirect      (redirect),
    .target        (sel_target)
  );

  assign pc_plus4  = pc_q + XLEN'(4);
  assign pc        = pc_q;
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    hold_d     = hold_q;
    load_instr = 1'b0;
    load_dat   = imem_rdata;
    imem_req   = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = !stall;
        if (imem_req && !imem_ready) begin
          // The request is in flight; a redirect now must wait for the response.
          state_d = WAIT;
          if (redirect) begin
            pend_d     = 1'b1;
            pend_tgt_d = sel_target;
          end
        end else if (redirect) begin
          pc_d = sel_target;
        end else if (imem_req) begin
          load_instr = 1'b1;
        end
      end

      WAIT: begin
        imem_req = 1'b1;
        if (redirect) begin
          pend_d     = 1'b1;
          pend_tgt_d = sel_target;
        end
        if (imem_ready) begin
          state_d = FETCH;
          if (pend_q || redirect) begin
            pc_d   = redirect ? sel_target : pend_tgt_q;
            pend_d = 1'b0;
          end else if (stall) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            load_instr = 1'b1;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          hold_d  = XLEN'(NOP_INSTR);
          pc_d    = sel_target;
          state_d = FETCH;
        end else if (!stall) begin
          load_instr = 1'b1;
          load_dat   = hold_q;
          hold_d     = XLEN'(NOP_INSTR);
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase

    if (load_instr) begin
      pc_d = pc_plus4;
    end

    // Flush squashes even a held IF/ID; otherwise stall freezes it.
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (if_flush || !stall) begin
      instr_d = XLEN'(NOP_INSTR);
      pc4_d   = '0;
      valid_d = 1'b0;
      if (load_instr && !if_flush) begin
        instr_d = load_dat;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      hold_q     <= '0;
      instr_q    <= XLEN'(NOP_INSTR);
      pc4_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      hold_q     <= hold_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule
